// File: rtl/rom_loader.sv
// rom_loader: writer side of the 2**ADDR_W x 8 program memory.
//   Receives a length-prefixed program as a valid/ready byte stream
//   (LEN_HI, LEN_LO, payload) and writes the payload sequentially from
//   LOAD_BASE. busy doubles as the CPU hold while a load is in progress.
//
// Build option:
//   ROM_LOADER_CHECKSUM_EN  when defined, a trailing checksum byte (8-bit sum
//                           of the payload) is accepted and compared after the
//                           payload; a mismatch sets error.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      1-cycle pulse, begins a new load (honoured in IDLE/DONE only)
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader accepts in_data this cycle
//   mem_we     memory write strobe, one pulse per payload byte
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   busy       load in progress (CPU hold)
//   done       load finished, held until the next start
//   error      load rejected or corrupt, meaningful while done = 1
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | waiting for the length high byte
// LEN_LO | waiting for the length low byte
// DATA   | writing payload bytes
// CHK    | waiting for the checksum byte (checksum build only)
// DONE   | load finished, done held, waiting for start

module rom_loader #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 12'h200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
`ifdef ROM_LOADER_CHECKSUM_EN
    CHK    = 3'd4,
`endif
    DONE   = 3'd5
  } state_t;

  // Largest payload that still fits between LOAD_BASE and the top of memory.
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   MAX_LEN = DEPTH - {1'b0, LOAD_BASE};
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic              accept;
  logic              hi_bad;
  logic [ADDR_W-1:0] len_full;
  logic              len_zero;
  logic              len_over;
  logic              last_byte;

  assign accept    = in_valid & in_ready;
  // Length bits above ADDR_W arrive in the top of the high byte; any set bit
  // means the program cannot fit at all.
  assign hi_bad    = (in_data >> (ADDR_W - 8)) != 8'd0;
  assign len_full  = {len_q[ADDR_W-1:8], in_data};
  assign len_zero  = (len_full == '0);
  assign len_over  = {1'b0, len_full} > MAX_LEN;
  assign last_byte = (cnt_q == (len_q - ONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (accept) state_nxt = hi_bad ? DONE : LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_nxt = (len_zero || len_over) ? DONE : DATA;
      end
      DATA: begin
        if (accept && last_byte) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      LEN_HI, LEN_LO, DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, write port, counters and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q <= '0;
            cnt_q <= '0;
            error <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_q[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
            if (hi_bad) error <= 1'b1;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= in_data;
            if (len_over) error <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= LOAD_BASE + cnt_q;
            mem_wdata <= in_data;
            cnt_q     <= cnt_q + ONE;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + in_data;
`endif
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept && (in_data != sum_q)) error <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader (ADDR_W = 12, LOAD_BASE = 0x200).
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  rom_loader #(.ADDR_W(12), .LOAD_BASE(12'h200)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_addr [8192];
  logic [7:0]  exp_data [8192];
  int          wcyc [8192];
  int          exp_n = 0;
  int          wr_total = 0;
  int          cyc = 0;
  logic [11:0] last_addr = '0;
  logic [7:0]  last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expected behaviour of one load, straight from the stream format:
  // queues the writes it implies, returns the expected error flag and the
  // number of bytes the loader should consume.
  task automatic model_load(input logic [7:0] b[$], output logic exp_err, output int consumed);
    int len;
    exp_err  = 1'b0;
    consumed = 1;
    if (b[0] > 8'h0F) begin
      exp_err = 1'b1;
      return;
    end
    consumed = 2;
    len = int'(b[0]) * 256 + int'(b[1]);
    if (len == 0) return;
    if (len > 4096 - 512) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_addr[exp_n] = 12'(512 + i);
      exp_data[exp_n] = b[2 + i];
      exp_n++;
    end
    consumed = 2 + len;
`ifdef ROM_LOADER_CHECKSUM_EN
    begin
      int sum;
      sum = 0;
      for (int i = 0; i < len; i++) sum = (sum + int'(b[2 + i])) % 256;
      consumed++;
      if (int'(b[2 + len]) != sum) exp_err = 1'b1;
    end
`endif
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      t++;
      if (t > 50) begin
        check("accept_timeout", 32'(t), 32'd0);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_load(input string name, input logic [7:0] b[$], input int max_gap,
                          input logic lit_err, input int lit_writes);
    logic merr;
    int   cons;
    int   base;
    base = wr_total;
    model_load(b, merr, cons);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy_start"}, 32'(busy), 32'd1);
    check({name, "_done_clr"}, 32'(done), 32'd0);
    for (int i = 0; i < cons; i++)
      send_byte(b[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_err_model"}, 32'(error), 32'(merr));
    check({name, "_err_lit"}, 32'(error), 32'(lit_err));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({name, "_writes"}, 32'(wr_total - base), 32'(lit_writes));
    check({name, "_done_held"}, 32'(done), 32'd1);
    check({name, "_ready_idle"}, 32'(in_ready), 32'd0);
    if (exp_n != wr_total) exp_n = wr_total;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int base;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
          check("busy_done_excl", 32'(busy & done), 32'd0);
          if (mem_we) begin
            check("wr_expected", 32'(wr_total < exp_n), 32'd1);
            if (wr_total < exp_n) begin
              check("wr_addr", 32'(mem_addr), 32'(exp_addr[wr_total]));
              check("wr_data", 32'(mem_wdata), 32'(exp_data[wr_total]));
            end
            if (wr_total < 8192) wcyc[wr_total] = cyc;
            last_addr = mem_addr;
            last_data = mem_wdata;
            wr_total++;
          end
        end
      end
    join_none

    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle with a byte on offer and no start: nothing taken, nothing written.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_we", 32'(mem_we), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    base = wr_total;
    q = {8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    run_load("basic", q, 0, 1'b0, 3);
    check("basic_last_addr", 32'(last_addr), 32'h202);
    check("basic_last_data", 32'(last_data), 32'hC3);
    check("basic_b2b_1", 32'(wcyc[base + 1] - wcyc[base]), 32'd1);
    check("basic_b2b_2", 32'(wcyc[base + 2] - wcyc[base]), 32'd2);

    q = {8'h00, 8'h00};
    run_load("len_zero", q, 0, 1'b0, 0);

    q = {8'h10};
    run_load("len_hi_bad", q, 0, 1'b1, 0);

    q = {8'h0F, 8'h00};
    run_load("len_over", q, 0, 1'b1, 0);

    q = {8'h0E, 8'h01};
    run_load("len_over1", q, 0, 1'b1, 0);

    q = {8'h00, 8'h01, 8'h7E};
    run_load("len_one", q, 1, 1'b0, 1);
    check("len_one_addr", 32'(last_addr), 32'h200);

    q = {8'h0E, 8'h00};
    for (int i = 0; i < 3584; i++) q.push_back(8'((i * 7 + 3) & 255));
`ifdef ROM_LOADER_CHECKSUM_EN
    begin
      int s;
      s = 0;
      for (int i = 0; i < 3584; i++) s = (s + ((i * 7 + 3) & 255)) % 256;
      q.push_back(8'(s));
    end
`endif
    run_load("len_max", q, 2, 1'b0, 3584);
    check("len_max_last_addr", 32'(last_addr), 32'hFFF);
    check("len_max_last_data", 32'(last_data), 32'hFC);

    // Reset in the middle of a 5-byte payload after two bytes are written.
    base = wr_total;
    q = {8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    begin
      logic merr;
      int   cons;
      model_load(q, merr, cons);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(q[i], 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_writes", 32'(wr_total - base), 32'd2);
    check("mid_rst_last", 32'(last_data), 32'h22);
    exp_n = wr_total;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q = {8'h00, 8'h02, 8'h5A, 8'hA5};
`ifdef ROM_LOADER_CHECKSUM_EN
    q.push_back(8'hFF);
`endif
    run_load("after_rst", q, 0, 1'b0, 2);
    check("after_rst_last", 32'(last_addr), 32'h201);

`ifdef ROM_LOADER_CHECKSUM_EN
    q = {8'h00, 8'h02, 8'h10, 8'h20, 8'h30};
    run_load("chk_ok", q, 0, 1'b0, 2);
    q = {8'h00, 8'h02, 8'h10, 8'h20, 8'h31};
    run_load("chk_bad", q, 1, 1'b1, 2);
    check("chk_bad_last", 32'(last_data), 32'h20);
    q = {8'h00, 8'h00};
    run_load("chk_len_zero", q, 0, 1'b0, 0);
`else
    q = {8'h00, 8'h02, 8'h10, 8'h20};
    run_load("nochk", q, 0, 1'b0, 2);
    check("nochk_last", 32'(last_data), 32'h20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
